// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: WIDTH-step shift-add multiply and restoring divide,
// signed variants via magnitudes with a sign/range fix-up cycle at the end.
module muldiv_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_hi,
  input  logic [WIDTH-1:0] a_lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             cf_of,
  output logic             div_err,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  // Handshake: start is a request taken on a rising edge only in IDLE or DONE (busy=0);
  // the result is signalled by a one-cycle done strobe and held until the next accepted start.
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_MAG   = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 accept;
  logic [1:0]           op_q;
  logic                 sign_res_q, sign_rem_q, pend_err_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opnd_q;
  logic [WIDTH-1:0]     res_lo_q, res_hi_q;
  logic                 cf_q, err_q;

  // Operand capture: magnitudes for signed ops and the early divide-error check
  logic               ld_div, ld_a_neg, ld_b_neg, ld_err;
  logic [WIDTH-1:0]   ld_b_mag, ld_lo_mag;
  logic [2*WIDTH-1:0] ld_dvd, ld_dvd_mag;

  always_comb begin
    ld_div     = op[1];
    ld_dvd     = {a_hi, a_lo};
    ld_a_neg   = op[0] & (ld_div ? a_hi[WIDTH-1] : a_lo[WIDTH-1]);
    ld_b_neg   = op[0] & b[WIDTH-1];
    ld_b_mag   = ld_b_neg ? -b : b;
    ld_lo_mag  = ld_a_neg ? -a_lo : a_lo;
    ld_dvd_mag = ld_a_neg ? -ld_dvd : ld_dvd;
    // A high half >= divisor means the quotient cannot fit in WIDTH bits (covers b == 0 too)
    ld_err     = ld_div & ((b == '0) | (ld_dvd_mag[2*WIDTH-1:WIDTH] >= ld_b_mag));
  end

  // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}
  logic [WIDTH:0] mul_sum, div_shift, div_trial;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
    div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    div_trial = div_shift - {1'b0, opnd_q};
    acc_d     = acc_q;
    if (op_q[1]) begin
      if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                   acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else if (acc_q[0]) begin
      acc_d = {mul_sum, acc_q[WIDTH-1:1]};
    end else begin
      acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    end
  end

  // Sign application, signed range check and flag computation
  logic [2*WIDTH-1:0] fx_prod;
  logic [WIDTH-1:0]   fx_quo, fx_rem, fx_hi, fx_lo;
  logic               fx_cf, fx_ovf;

  always_comb begin
    fx_prod = sign_res_q ? -acc_q : acc_q;
    fx_quo  = sign_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    fx_rem  = sign_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    fx_ovf  = op_q[1] & op_q[0] &
              (sign_res_q ? (acc_q[WIDTH-1:0] > MIN_MAG) : acc_q[WIDTH-1]);
    fx_hi   = fx_prod[2*WIDTH-1:WIDTH];
    fx_lo   = fx_prod[WIDTH-1:0];
    fx_cf   = 1'b0;
    if (op_q[1]) begin
      fx_hi = fx_rem;
      fx_lo = fx_quo;
    end else if (op_q[0]) begin
      fx_cf = (fx_hi != {WIDTH{fx_lo[WIDTH-1]}});
    end else begin
      fx_cf = (fx_hi != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          accept  = 1'b1;
          state_d = ld_err ? FIX : CALC;
        end
      end
      CALC:    if (cnt_q == LAST_STEP) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q       <= '0;
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
      pend_err_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      res_lo_q   <= '0;
      res_hi_q   <= '0;
      cf_q       <= 1'b0;
      err_q      <= 1'b0;
    end else if (accept) begin
      op_q       <= op;
      sign_res_q <= ld_a_neg ^ ld_b_neg;
      sign_rem_q <= ld_a_neg;
      pend_err_q <= ld_err;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      acc_q      <= ld_div ? ld_dvd_mag : {{WIDTH{1'b0}}, ld_b_mag};
      opnd_q     <= ld_div ? ld_b_mag : ld_lo_mag;
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
    end else if (state_q == FIX) begin
      if (pend_err_q | fx_ovf) begin
        err_q <= 1'b1;
      end else begin
        res_lo_q <= fx_lo;
        res_hi_q <= fx_hi;
        cf_q     <= fx_cf;
      end
    end
  end

  assign res_lo    = res_lo_q;
  assign res_hi    = res_hi_q;
  assign cf_of     = cf_q;
  assign div_err   = err_q;
  assign busy      = (state_q == CALC) || (state_q == FIX);
  assign done      = (state_q == DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a WIDTH=16 and a WIDTH=8 instance share clock and reset.
module tb_muldiv_unit;

  localparam logic [1:0] MUL = 2'b00, IMUL = 2'b01, DIV = 2'b10, IDIV = 2'b11;

  logic        clock = 1'b0;
  logic        reset_n;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        start16, start8;
  logic [1:0]  op16, op8;
  logic [15:0] ahi16, alo16, b16, rlo16, rhi16;
  logic [7:0]  ahi8, alo8, b8, rlo8, rhi8;
  logic        cf16, err16, busy16, done16, cf8, err8, busy8, done8;
  logic [1:0]  st16, st8;

  always #5 clock = ~clock;

  muldiv_unit #(.WIDTH(16)) u16 (
    .clock(clock), .reset_n(reset_n), .start(start16), .op(op16),
    .a_hi(ahi16), .a_lo(alo16), .b(b16), .res_lo(rlo16), .res_hi(rhi16),
    .cf_of(cf16), .div_err(err16), .busy(busy16), .done(done16), .dbg_state(st16)
  );

  muldiv_unit #(.WIDTH(8)) u8 (
    .clock(clock), .reset_n(reset_n), .start(start8), .op(op8),
    .a_hi(ahi8), .a_lo(alo8), .b(b8), .res_lo(rlo8), .res_hi(rhi8),
    .cf_of(cf8), .div_err(err8), .busy(busy8), .done(done8), .dbg_state(st8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Start is driven just after edge t and sampled at t+1; lat counts edges from t to done.
  // A second start with junk operands is driven while busy when glitch_at > 0.
  task automatic run16(input logic [1:0] o, input logic [15:0] ah, input logic [15:0] al,
                       input logic [15:0] bb, input int glitch_at,
                       output int lat, output logic busy_first);
    @(posedge clock); #1;
    op16 = o; ahi16 = ah; alo16 = al; b16 = bb; start16 = 1'b1;
    lat = 0;
    busy_first = 1'b0;
    do begin
      @(posedge clock); #1;
      lat++;
      if (lat == 1) busy_first = busy16;
      if (lat == glitch_at) begin
        start16 = 1'b1; op16 = MUL; alo16 = 16'h1234; b16 = 16'h0077;
      end else begin
        start16 = 1'b0;
      end
    end while (!done16 && lat < 64);
    start16 = 1'b0;
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] ah, input logic [7:0] al,
                      input logic [7:0] bb, output int lat);
    @(posedge clock); #1;
    op8 = o; ahi8 = ah; alo8 = al; b8 = bb; start8 = 1'b1;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
      start8 = 1'b0;
    end while (!done8 && lat < 64);
  endtask

  initial begin
    int   lat;
    logic bf;
    int   pulses;

    reset_n = 1'b0;
    start16 = 1'b0; op16 = MUL; ahi16 = '0; alo16 = '0; b16 = '0;
    start8  = 1'b0; op8  = MUL; ahi8  = '0; alo8  = '0; b8  = '0;
    #12;
    check("reset_res16", {rhi16, rlo16}, 32'h0);
    check("reset_flags16", {28'h0, cf16, err16, busy16, done16}, 32'h0);
    check("reset_state16", {30'h0, st16}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Unsigned divide: 0x10000 / 3 = 0x5555 remainder 1
    run16(DIV, 16'h0001, 16'h0000, 16'h0003, 0, lat, bf);
    check("div_lat", lat, 18);
    check("div_res", {rhi16, rlo16}, {16'h0001, 16'h5555});
    check("div_flags", {30'h0, cf16, err16}, 32'h0);

    // Signed multiply -1 * 2 with an ignored start while busy
    run16(IMUL, 16'h0000, 16'hFFFF, 16'h0002, 5, lat, bf);
    check("imul_lat", lat, 18);
    check("imul_busy", {31'h0, bf}, 32'h1);
    check("imul_res", {rhi16, rlo16}, 32'hFFFF_FFFE);
    check("imul_cf", {31'h0, cf16}, 32'h0);

    // Largest unsigned product
    run16(MUL, 16'h0000, 16'hFFFF, 16'hFFFF, 0, lat, bf);
    check("mul_lat", lat, 18);
    check("mul_done_busy", {30'h0, done16, busy16}, 32'h2);
    check("mul_res", {rhi16, rlo16}, 32'hFFFE_0001);
    check("mul_cf", {31'h0, cf16}, 32'h1);
    @(posedge clock); #1;
    check("done_one_cycle", {31'h0, done16}, 32'h0);
    check("back_to_idle", {30'h0, st16}, 32'h0);

    // Divide by zero: short path, results and cf untouched
    run16(DIV, 16'h0000, 16'h0010, 16'h0000, 0, lat, bf);
    check("div0_lat", lat, 2);
    check("div0_busy", {31'h0, bf}, 32'h1);
    check("div0_err", {31'h0, err16}, 32'h1);
    check("div0_res", {rhi16, rlo16}, 32'hFFFE_0001);
    check("div0_cf", {31'h0, cf16}, 32'h1);

    // Quotient overflow detected at load: a_hi == b
    run16(DIV, 16'h0005, 16'h0000, 16'h0005, 0, lat, bf);
    check("divov_lat", lat, 2);
    check("divov_err", {31'h0, err16}, 32'h1);
    check("divov_res", {rhi16, rlo16}, 32'hFFFE_0001);
    repeat (3) @(posedge clock);
    #1;
    check("err_held", {31'h0, err16}, 32'h1);

    // Next accepted start clears div_err
    run16(MUL, 16'h0000, 16'h0003, 16'h0005, 0, lat, bf);
    check("clr_err", {31'h0, err16}, 32'h0);
    check("small_mul", {rhi16, rlo16}, 32'h0000_000F);
    check("small_mul_cf", {31'h0, cf16}, 32'h0);

    // Reset in the middle of a multiply
    @(posedge clock); #1;
    op16 = MUL; alo16 = 16'hFFFF; b16 = 16'hFFFF; start16 = 1'b1;
    repeat (5) begin
      @(posedge clock); #1;
      start16 = 1'b0;
    end
    reset_n = 1'b0;
    #1;
    check("abort_res", {rhi16, rlo16}, 32'h0);
    check("abort_flags", {28'h0, cf16, err16, busy16, done16}, 32'h0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(posedge clock); #1;
      if (done16) pulses++;
    end
    check("abort_no_done", pulses, 0);
    run16(MUL, 16'h0000, 16'h1234, 16'h0010, 0, lat, bf);
    check("post_rst_lat", lat, 18);
    check("post_rst_res", {rhi16, rlo16}, 32'h0001_2340);
    check("post_rst_cf", {31'h0, cf16}, 32'h1);

    // WIDTH=8: -7 / 2 = -3 remainder -1
    run8(IDIV, 8'hFF, 8'hF9, 8'h02, lat);
    check("idiv8_lat", lat, 10);
    check("idiv8_res", {16'h0, rhi8, rlo8}, 32'h0000_FFFD);
    check("idiv8_err", {31'h0, err8}, 32'h0);

    // -128 / 1 is the most negative representable quotient
    run8(IDIV, 8'hFF, 8'h80, 8'h01, lat);
    check("idiv8_min", {16'h0, rhi8, rlo8}, 32'h0000_0080);
    check("idiv8_min_err", {31'h0, err8}, 32'h0);

    // +128 / 1 overflows in the fix-up cycle: normal timing, results kept
    run8(IDIV, 8'h00, 8'h80, 8'h01, lat);
    check("idiv8_ovf_lat", lat, 10);
    check("idiv8_ovf_err", {31'h0, err8}, 32'h1);
    check("idiv8_ovf_res", {16'h0, rhi8, rlo8}, 32'h0000_0080);

    // |dividend| high half >= |b| flagged at load
    run8(IDIV, 8'hFE, 8'h00, 8'hFE, lat);
    check("idiv8_ld_lat", lat, 2);
    check("idiv8_ld_err", {31'h0, err8}, 32'h1);

    // (-128) * (-128) = 0x4000
    run8(IMUL, 8'h00, 8'h80, 8'h80, lat);
    check("imul8_res", {16'h0, rhi8, rlo8}, 32'h0000_4000);
    check("imul8_cf", {31'h0, cf8}, 32'h1);
    check("imul8_err", {31'h0, err8}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
